// File: rtl/serial_bit_feeder_if.sv
// Word-in / bit-out bundle for serial_bit_feeder.
// The master side produces words and consumes the serial stream;
// the slave side is the feeder itself.
interface serial_bit_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             serial_out;
  logic             serial_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  serial_out,
    input  serial_valid,
    input  frame_start,
    input  busy
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output serial_out,
    output serial_valid,
    output frame_start,
    output busy
  );
endinterface

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-to-serial front end for the pair detector.
// Words land in a one-entry holding register and are shifted out one bit
// per clock, MSB- or LSB-first, optionally followed by IDLE_GAP forced-zero
// cycles. All outputs are registered; nothing on the input side reaches an
// output without passing through a flop.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int IDLE_GAP  = 0
) (
  input  logic                clk,
  input  logic                reset,
  serial_bit_feeder_if.slave  bus_if
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam bit              HAS_GAP  = (IDLE_GAP > 0);
  localparam logic [3:0]      GAP_LAST = HAS_GAP ? 4'(IDLE_GAP - 1) : 4'd0;

  // Elaboration-time guard on the legal parameter ranges.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("serial_bit_feeder: WIDTH must be in 2..32");
  end
  if (IDLE_GAP < 0 || IDLE_GAP > 15) begin : g_bad_gap
    $error("serial_bit_feeder: IDLE_GAP must be in 0..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Architectural state
  state_t            state_q,      state_d;
  logic [WIDTH-1:0]  hold_q,       hold_d;
  logic              hold_full_q,  hold_full_d;
  logic [WIDTH-1:0]  sreg_q,       sreg_d;
  logic [CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
  logic [3:0]        gap_cnt_q,    gap_cnt_d;

  // Registered outputs, computed from the next architectural state
  logic              serial_out_q,   serial_out_d;
  logic              serial_valid_q, serial_valid_d;
  logic              frame_start_q,  frame_start_d;
  logic              busy_q,         busy_d;
  logic              din_ready_q,    din_ready_d;

  // Decoded conditions on the current state
  logic              accept;
  logic              last_bit;
  logic              last_gap;
  logic              shifter_free;

  // sreg moved one place toward its output end, zero filled behind.
  logic [WIDTH-1:0]  sreg_shifted;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST != 0) begin : g_msb
        if (gi == 0) begin : g_fill
          assign sreg_shifted[gi] = 1'b0;
        end else begin : g_move
          assign sreg_shifted[gi] = sreg_q[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_fill
          assign sreg_shifted[gi] = 1'b0;
        end else begin : g_move
          assign sreg_shifted[gi] = sreg_q[gi+1];
        end
      end
    end
  endgenerate

  // Next-state logic: advance the shifter, reload from hold when free,
  // capture a new word into hold, then derive the outputs for next cycle.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    sreg_d       = sreg_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;

    // din_ready is exactly !hold_full, so an accept can never land on the
    // same edge as a load out of hold.
    accept       = bus_if.din_valid && !hold_full_q;
    last_bit     = (state_q == ST_SHIFT) && (bit_cnt_q == BIT_LAST);
    last_gap     = (state_q == ST_GAP) && (gap_cnt_q == GAP_LAST);
    shifter_free = (state_q == ST_IDLE) || (last_bit && !HAS_GAP) || last_gap;

    unique case (state_q)
      ST_SHIFT: begin
        sreg_d    = sreg_shifted;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (last_bit) begin
          if (HAS_GAP) begin
            state_d   = ST_GAP;
            gap_cnt_d = 4'd0;
          end else begin
            state_d   = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + 4'd1;
        if (last_gap) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A held word takes over the shifter the moment it frees up, which is
    // what makes back-to-back words bubble-free when there is no gap.
    if (shifter_free && hold_full_q) begin
      sreg_d      = hold_q;
      hold_full_d = 1'b0;
      bit_cnt_d   = '0;
      state_d     = ST_SHIFT;
    end

    if (accept) begin
      hold_d      = bus_if.din;
      hold_full_d = 1'b1;
    end

    serial_valid_d = (state_d == ST_SHIFT);
    serial_out_d   = serial_valid_d &&
                     ((MSB_FIRST != 0) ? sreg_d[WIDTH-1] : sreg_d[0]);
    frame_start_d  = serial_valid_d && (bit_cnt_d == '0);
    busy_d         = (state_d != ST_IDLE) || hold_full_d;
    din_ready_d    = !hold_full_d;
  end

  // State and output registers; reset drops any held or in-flight word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      hold_q         <= '0;
      hold_full_q    <= 1'b0;
      sreg_q         <= '0;
      bit_cnt_q      <= '0;
      gap_cnt_q      <= 4'd0;
      serial_out_q   <= 1'b0;
      serial_valid_q <= 1'b0;
      frame_start_q  <= 1'b0;
      busy_q         <= 1'b0;
      din_ready_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      hold_full_q    <= hold_full_d;
      sreg_q         <= sreg_d;
      bit_cnt_q      <= bit_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      serial_out_q   <= serial_out_d;
      serial_valid_q <= serial_valid_d;
      frame_start_q  <= frame_start_d;
      busy_q         <= busy_d;
      din_ready_q    <= din_ready_d;
    end
  end

  assign bus_if.din_ready    = din_ready_q;
  assign bus_if.serial_out   = serial_out_q;
  assign bus_if.serial_valid = serial_valid_q;
  assign bus_if.frame_start  = frame_start_q;
  assign bus_if.busy         = busy_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: three instances (MSB-first no gap, LSB-first
// no gap, MSB-first with a 2-cycle gap) checked every cycle against a
// word-timeline model, plus literal expectations for the directed vectors.
module tb_serial_bit_feeder;

  localparam int W          = 8;
  localparam int MSBF  [3]  = '{1, 0, 1};
  localparam int GAP_P [3]  = '{0, 0, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_bit_feeder_if #(.WIDTH(W)) if_a ();
  serial_bit_feeder_if #(.WIDTH(W)) if_b ();
  serial_bit_feeder_if #(.WIDTH(W)) if_c ();

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1), .IDLE_GAP(0))
    dut_a (.clk(clk), .reset(rst), .bus_if(if_a));
  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(0), .IDLE_GAP(0))
    dut_b (.clk(clk), .reset(rst), .bus_if(if_b));
  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1), .IDLE_GAP(2))
    dut_c (.clk(clk), .reset(rst), .bus_if(if_c));

  // Producer drives, per instance
  logic [W-1:0] din_v [3];
  logic         val_v [3];
  // DUT outputs, per instance
  logic so_w [3], sv_w [3], fs_w [3], bz_w [3], rdy_w [3];

  assign if_a.din = din_v[0];  assign if_a.din_valid = val_v[0];
  assign if_b.din = din_v[1];  assign if_b.din_valid = val_v[1];
  assign if_c.din = din_v[2];  assign if_c.din_valid = val_v[2];

  assign so_w[0] = if_a.serial_out;   assign so_w[1] = if_b.serial_out;   assign so_w[2] = if_c.serial_out;
  assign sv_w[0] = if_a.serial_valid; assign sv_w[1] = if_b.serial_valid; assign sv_w[2] = if_c.serial_valid;
  assign fs_w[0] = if_a.frame_start;  assign fs_w[1] = if_b.frame_start;  assign fs_w[2] = if_c.frame_start;
  assign bz_w[0] = if_a.busy;         assign bz_w[1] = if_b.busy;         assign bz_w[2] = if_c.busy;
  assign rdy_w[0] = if_a.din_ready;   assign rdy_w[1] = if_b.din_ready;   assign rdy_w[2] = if_c.din_ready;

  // ---------------- Model: a timeline of word slots ----------------
  // Cycle n is the interval after edge n. A word loaded at edge L owns bit
  // cycles L..L+W-1; the next load can come no earlier than edge L+W+gap.
  int           ecount        = 0;
  bit           mhf    [3]    = '{0, 0, 0};
  logic [W-1:0] mhold  [3]    = '{8'h0, 8'h0, 8'h0};
  logic [W-1:0] mword  [3]    = '{8'h0, 8'h0, 8'h0};
  int           mstart [3]    = '{-100, -100, -100};
  int           mfree  [3]    = '{0, 0, 0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        mhf[i]    <= 1'b0;
        mstart[i] <= -100;
        mfree[i]  <= 0;
      end
    end else begin
      ecount <= ecount + 1;
      for (int i = 0; i < 3; i++) begin
        if (mhf[i] && (ecount + 1) >= mfree[i]) begin
          mstart[i] <= ecount + 1;
          mword[i]  <= mhold[i];
          mfree[i]  <= ecount + 1 + W + GAP_P[i];
        end
        if (val_v[i] && !mhf[i]) begin
          mhf[i]   <= 1'b1;
          mhold[i] <= din_v[i];
        end else if (mhf[i] && (ecount + 1) >= mfree[i]) begin
          mhf[i]   <= 1'b0;
        end
      end
    end
  end

  // ---------------- Bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  // logs: [instance][kind 0=out 1=valid 2=frame 3=busy][cycle]
  logic dlog [3][4][2048];
  logic mlog [3][4][2048];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 48 cycles of one signal, starting at the first valid cycle >= t0
  function automatic logic [47:0] pack_log(input int i, input int t0, input int kind, input bit use_model);
    logic [47:0] r;
    int first;
    first = -1;
    for (int c = t0; c < ecount && c < 2048; c++) begin
      if (first < 0 && (use_model ? mlog[i][1][c] : dlog[i][1][c]) === 1'b1) first = c;
    end
    if (first < 0 || first + 48 > 2048) return '1;
    for (int k = 0; k < 48; k++)
      r[47-k] = use_model ? mlog[i][kind][first+k] : dlog[i][kind][first+k];
    return r;
  endfunction

  task automatic send_word(input int i, input logic [W-1:0] w, input bit junk);
    int budget;
    budget = 0;
    val_v[i] = 1'b1;
    din_v[i] = junk ? W'($urandom) : w;
    while (rdy_w[i] !== 1'b1 && budget < 200) begin
      if (junk) din_v[i] = W'($urandom);
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout inst%0d: din_ready stayed %b, required 1", i, rdy_w[i]);
    end
    din_v[i] = w;
    @(posedge clk); #1;
  endtask

  task automatic drop(input int i);
    val_v[i] = 1'b0;
    din_v[i] = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- Main ----------------
  initial begin : main
    int t0;
    for (int i = 0; i < 3; i++) begin
      din_v[i] = '0;
      val_v[i] = 1'b0;
    end

    // Per-cycle comparison of every output against the model
    fork
      begin : cmp
        int idx;
        logic e_so, e_sv, e_fs, e_bz, e_rdy;
        forever begin
          @(negedge clk);
          for (int i = 0; i < 3; i++) begin
            idx   = ecount - mstart[i];
            e_sv  = (idx >= 0 && idx < W);
            e_so  = 1'b0;
            if (e_sv) e_so = (MSBF[i] != 0) ? mword[i][W-1-idx] : mword[i][idx];
            e_fs  = (idx == 0);
            e_bz  = mhf[i] || (ecount < mfree[i]);
            e_rdy = !mhf[i];
            chk($sformatf("inst%0d serial_out", i),   {47'h0, so_w[i]},  {47'h0, e_so});
            chk($sformatf("inst%0d serial_valid", i), {47'h0, sv_w[i]},  {47'h0, e_sv});
            chk($sformatf("inst%0d frame_start", i),  {47'h0, fs_w[i]},  {47'h0, e_fs});
            chk($sformatf("inst%0d busy", i),         {47'h0, bz_w[i]},  {47'h0, e_bz});
            chk($sformatf("inst%0d din_ready", i),    {47'h0, rdy_w[i]}, {47'h0, e_rdy});
            if (ecount < 2048) begin
              dlog[i][0][ecount] = so_w[i]; dlog[i][1][ecount] = sv_w[i];
              dlog[i][2][ecount] = fs_w[i]; dlog[i][3][ecount] = bz_w[i];
              mlog[i][0][ecount] = e_so;    mlog[i][1][ecount] = e_sv;
              mlog[i][2][ecount] = e_fs;    mlog[i][3][ecount] = e_bz;
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset din_ready", {47'h0, rdy_w[0]}, 48'h1);
    chk("reset busy",      {47'h0, bz_w[0]},  48'h0);
    chk("reset valid",     {47'h0, sv_w[0]},  48'h0);

    // Single word 8'hB4, MSB first
    t0 = ecount;
    send_word(0, 8'hB4, 1'b0);
    drop(0);
    chk("t1 cycle k valid",  {47'h0, sv_w[0]},  48'h0);
    chk("t1 cycle k busy",   {47'h0, bz_w[0]},  48'h1);
    chk("t1 cycle k ready",  {47'h0, rdy_w[0]}, 48'h0);
    @(posedge clk); #1;
    chk("t1 cycle k+1 valid", {47'h0, sv_w[0]}, 48'h1);
    chk("t1 cycle k+1 frame", {47'h0, fs_w[0]}, 48'h1);
    chk("t1 cycle k+1 out",   {47'h0, so_w[0]}, 48'h1);
    idle(50);
    chk("t1 bits",        pack_log(0, t0, 0, 0), {8'hB4, 40'h0});
    chk("t1 valid",       pack_log(0, t0, 1, 0), {8'hFF, 40'h0});
    chk("t1 frame",       pack_log(0, t0, 2, 0), {8'h80, 40'h0});
    chk("t1 busy",        pack_log(0, t0, 3, 0), {8'hFF, 40'h0});
    chk("t1 model bits",  pack_log(0, t0, 0, 1), {8'hB4, 40'h0});

    // Back-to-back 8'hFF, 8'h03 with din_valid held
    t0 = ecount;
    send_word(0, 8'hFF, 1'b0);
    send_word(0, 8'h03, 1'b0);
    drop(0);
    idle(50);
    chk("t2 bits",  pack_log(0, t0, 0, 0), {16'hFF03, 32'h0});
    chk("t2 valid", pack_log(0, t0, 1, 0), {16'hFFFF, 32'h0});
    chk("t2 frame", pack_log(0, t0, 2, 0), {16'h8080, 32'h0});
    chk("t2 model frame", pack_log(0, t0, 2, 1), {16'h8080, 32'h0});

    // LSB first: 8'h01 then 8'h80
    t0 = ecount;
    send_word(1, 8'h01, 1'b0);
    drop(1);
    idle(50);
    chk("t3a bits",  pack_log(1, t0, 0, 0), {8'h80, 40'h0});
    chk("t3a frame", pack_log(1, t0, 2, 0), {8'h80, 40'h0});
    chk("t3a model bits", pack_log(1, t0, 0, 1), {8'h80, 40'h0});
    t0 = ecount;
    send_word(1, 8'h80, 1'b0);
    drop(1);
    idle(50);
    chk("t3b bits",  pack_log(1, t0, 0, 0), {8'h01, 40'h0});

    // Gap of 2 between two queued 8'hC0 words
    t0 = ecount;
    send_word(2, 8'hC0, 1'b0);
    send_word(2, 8'hC0, 1'b0);
    drop(2);
    idle(50);
    chk("t4 bits",  pack_log(2, t0, 0, 0), {24'hC03000, 24'h0});
    chk("t4 valid", pack_log(2, t0, 1, 0), {24'hFF3FC0, 24'h0});
    chk("t4 frame", pack_log(2, t0, 2, 0), {24'h802000, 24'h0});
    chk("t4 model valid", pack_log(2, t0, 1, 1), {24'hFF3FC0, 24'h0});

    // Reset mid-word with a second word held
    send_word(0, 8'hFF, 1'b0);
    send_word(0, 8'h55, 1'b0);
    drop(0);
    @(posedge clk); #1;
    chk("t5 pre-reset busy", {47'h0, bz_w[0]}, 48'h1);
    #1 rst = 1'b1;
    #1;
    chk("t5 reset out",   {47'h0, so_w[0]},  48'h0);
    chk("t5 reset valid", {47'h0, sv_w[0]},  48'h0);
    chk("t5 reset busy",  {47'h0, bz_w[0]},  48'h0);
    chk("t5 reset ready", {47'h0, rdy_w[0]}, 48'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    t0 = ecount;
    send_word(0, 8'hA5, 1'b0);
    drop(0);
    idle(50);
    chk("t5 bits",  pack_log(0, t0, 0, 0), {8'hA5, 40'h0});
    chk("t5 frame", pack_log(0, t0, 2, 0), {8'h80, 40'h0});

    // Backpressure with din changing while not ready
    t0 = ecount;
    send_word(0, 8'h3C, 1'b1);
    send_word(0, 8'h81, 1'b1);
    send_word(0, 8'hE7, 1'b1);
    send_word(0, 8'h5A, 1'b1);
    drop(0);
    idle(60);
    chk("t6 bits",  pack_log(0, t0, 0, 0), {32'h3C81E75A, 16'h0});
    chk("t6 valid", pack_log(0, t0, 1, 0), {32'hFFFFFFFF, 16'h0});
    chk("t6 frame", pack_log(0, t0, 2, 0), {32'h80808080, 16'h0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_bit_feeder.md
# serial_bit_feeder

Parallel-to-serial front end that turns handshaked WIDTH-bit words into the single-bit stream consumed by the pair detector's `inbits` input. Words are buffered in a one-entry holding register and shifted out one bit per clock, MSB- or LSB-first. Words can stream back-to-back with no gap, or be separated by a programmable run of forced-zero idle cycles so the downstream detector's state is flushed between words. Idle output is always 0.

## Interface
Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = din[WIDTH-1] is sent first; 0 = din[0] is sent first.
- IDLE_GAP, 0, number of forced-zero cycles inserted after every word; legal range 0..15.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- din  input  WIDTH  word to serialize; sampled on accept.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  = !hold_full; accept happens when din_valid && din_ready at a rising edge.
- serial_out  output  1  bit stream to the pair detector; 0 whenever serial_valid=0.
- serial_valid  output  1  high while a data bit is on serial_out.
- frame_start  output  1  high only during the first bit of each word.
- busy  output  1  high if a word is held or in flight (state != IDLE or hold_full).

## Operation
- Storage: hold register plus hold_full flag; shift register sreg; bit counter of $clog2(WIDTH) bits; gap counter of 4 bits.
- Accept: on an edge with din_valid && din_ready, din is copied into hold and hold_full is set.
- States: IDLE, SHIFT, GAP.
- Load condition ("shifter free"):
  - state is IDLE; or
  - state is SHIFT on the last bit with IDLE_GAP=0; or
  - state is GAP on its last gap cycle.
- Load: if shifter free and hold_full, then hold goes to sreg, hold_full clears, the bit counter goes to 0, and the state becomes SHIFT.
- IDLE: serial_valid=0, serial_out=0. Move to SHIFT on load.
- SHIFT: serial_out is sreg[WIDTH-1] (MSB_FIRST=1) or sreg[0] (MSB_FIRST=0), and serial_valid=1. Each edge shifts sreg toward the output end and increments the counter.
- On the last bit (counter = WIDTH-1):
  - IDLE_GAP>0: go to GAP with gap counter = 0.
  - IDLE_GAP=0: load if hold_full, otherwise go to IDLE.
- GAP: serial_out=0, serial_valid=0 for exactly IDLE_GAP cycles. Then load if hold_full, otherwise go to IDLE.
- frame_start is 1 when state=SHIFT and counter=0.
- Accept and load on the same edge cannot collide, because din_ready is low whenever hold_full=1. An accept while the shifter is busy simply waits in hold.
- Backpressure: while hold_full=1, din_ready=0. The producer must hold din and din_valid. No word is dropped or duplicated.
- Outputs are decoded from registered state only; there is no combinational path from din or din_valid to any output.

## Timing
- Reset values (asynchronous, effective immediately):
  - state=IDLE, hold_full=0, sreg=0, counters=0.
  - serial_out=0, serial_valid=0, frame_start=0, busy=0, din_ready=1.
- Latency: a word accepted at edge k is loaded at edge k+1 if the shifter is free. Its bits then occupy cycles k+1 .. k+WIDTH, with frame_start in cycle k+1 only.
- Throughput with IDLE_GAP=0: the hold register refills in time, so continuous words give one valid bit every cycle with no bubble.
- Throughput with IDLE_GAP=G: the word period is WIDTH+G cycles.
- Reset mid-word or mid-gap: the in-flight word and any held word are discarded. The next accepted word starts from bit 0 with frame_start asserted.
- din_ready returns high the cycle after hold empties.
- Downstream view: idle and gap cycles present 0 on serial_out, which returns the pair detector to its initial state.

## Test plan
- Single word (WIDTH=8, MSB_FIRST=1, IDLE_GAP=0), din=8'hB4 accepted at edge k -> serial_out = 1,0,1,1,0,1,0,0 in cycles k+1..k+8; serial_valid high for those 8 cycles only; frame_start only in cycle k+1; busy falls after cycle k+8.
- Back-to-back words 8'hFF then 8'h03, with din_valid held high -> 16 contiguous valid bits 1111111100000011 with no idle cycle; frame_start in bit cycles 1 and 9; din_ready low while hold is full.
- LSB-first (MSB_FIRST=0), din=8'h01 -> serial_out = 1 then seven 0s; din=8'h80 -> seven 0s then 1.
- Gap insertion (IDLE_GAP=2), two queued words of 8'hC0 -> bits 11000000, then 2 cycles with serial_valid=0 and serial_out=0, then 11000000; the word period is 10 cycles.
- Reset asserted after the 3rd bit of 8'hFF, with a second word held -> serial_out=0, serial_valid=0, busy=0, din_ready=1 immediately; after release, a new word 8'hA5 emits 10100101 from bit 0 with frame_start.
- Backpressure: din_valid held high with changing din while hold_full=1 -> each word is accepted exactly once; the output sequence matches the accepted words in order.
